// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one combinational ALU. Each cycle at most one
// requester is granted; its operation is evaluated by the shared ALU and the
// result is captured in that requester's own result register on the clock
// edge where the request handshake completes. Each result register is a
// single-entry skid-free buffer: a port may be granted again only when its
// register is empty or is being drained on the same edge, which gives one
// operation per cycle per port when the consumer keeps up.
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> conflicts resolved round-robin using a 1-bit
//                               last-grant pointer (port 0 wins first after
//                               reset).
//                  undefined -> fixed priority, port 0 always wins conflicts.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst_n                asynchronous active-low reset
//   req0_valid/req1_valid requester i presents an operation
//   req0_ready/req1_ready operation accepted when valid & ready on an edge
//   req0_a/b, req1_a/b   32-bit operands
//   req0_oper/req1_oper  4-bit EXE_ALU_* operation code
//   req0_sign/req1_sign  signed select for SLT and SR
//   rsp0_valid/rsp1_valid result register i holds an undelivered result
//   rsp0_ready/rsp1_ready consumer i takes the result when valid & ready
//   rsp0_result/rsp1_result result register contents
//
// EXE_ALU_* encoding:
//   0 ADD   1 ADDU  2 SUB   3 SUBU  4 AND   5 OR    6 XOR   7 NOR
//   8 SLT   9 SL   10 SR   11..15 undefined (result 0)
//   Shifts take the shift amount from operand a and shift operand b.
// -----------------------------------------------------------------------------

`default_nettype none

// -----------------------------------------------------------------------------
// alu
//
// Purely combinational ALU.
// Ports:
//   a, b    operands
//   oper    EXE_ALU_* operation code
//   sign    signed select for SLT (compare) and SR (arithmetic shift)
//   result  operation result, 0 for undefined codes
// -----------------------------------------------------------------------------
module alu #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        oper,
   input  logic              sign,
   output logic [DATA_W-1:0] result
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [3:0] EXE_ALU_ADD  = 4'd0;
   localparam logic [3:0] EXE_ALU_ADDU = 4'd1;
   localparam logic [3:0] EXE_ALU_SUB  = 4'd2;
   localparam logic [3:0] EXE_ALU_SUBU = 4'd3;
   localparam logic [3:0] EXE_ALU_AND  = 4'd4;
   localparam logic [3:0] EXE_ALU_OR   = 4'd5;
   localparam logic [3:0] EXE_ALU_XOR  = 4'd6;
   localparam logic [3:0] EXE_ALU_NOR  = 4'd7;
   localparam logic [3:0] EXE_ALU_SLT  = 4'd8;
   localparam logic [3:0] EXE_ALU_SL   = 4'd9;
   localparam logic [3:0] EXE_ALU_SR   = 4'd10;

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic signed [DATA_W-1:0] sra;
   logic        [DATA_W-1:0] srl;
   logic        [SH_W-1:0]   shamt;
   logic                     lt;

   assign a_s   = a;
   assign b_s   = b;
   assign shamt = a[SH_W-1:0];

   // The arithmetic shift is kept in its own signed net: inside a mixed
   // signed/unsigned conditional it would silently degrade to a logical shift.
   assign sra = b_s >>> shamt;
   assign srl = b >> shamt;
   assign lt  = sign ? (a_s < b_s) : (a < b);

   always_comb begin
      result = '0;
      case (oper)
         EXE_ALU_ADD,
         EXE_ALU_ADDU: result = a + b;
         EXE_ALU_SUB,
         EXE_ALU_SUBU: result = a - b;
         EXE_ALU_AND:  result = a & b;
         EXE_ALU_OR:   result = a | b;
         EXE_ALU_XOR:  result = a ^ b;
         EXE_ALU_NOR:  result = ~(a | b);
         EXE_ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt};
         EXE_ALU_SL:   result = b << shamt;
         EXE_ALU_SR:   result = sign ? sra : srl;
         default:      result = '0;
      endcase
   end

endmodule

// -----------------------------------------------------------------------------
// alu_arbiter (top)
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [3:0]        req0_oper,
   input  logic              req0_sign,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [3:0]        req1_oper,
   input  logic              req1_sign,

   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,

   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result
);

   logic              elig0;
   logic              elig1;
   logic              grant0;
   logic              grant1;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_oper;
   logic              alu_sign;
   logic [DATA_W-1:0] alu_y;

   logic              vld0_p1;
   logic              vld1_p1;
   logic [DATA_W-1:0] result0_p1;
   logic [DATA_W-1:0] result1_p1;

   // A port can take a new operation only if its result slot is free or is
   // being emptied on this very edge. rst_n gates eligibility so that nothing
   // is offered or accepted while reset is held.
   assign elig0 = rst_n & req0_valid & (~vld0_p1 | rsp0_ready);
   assign elig1 = rst_n & req1_valid & (~vld1_p1 | rsp1_ready);

`ifdef ALU_ARB_RR_EN
   // Round-robin: on conflict the port that did not win last time is served.
   // last_grant resets to 1 so port 0 wins the first conflict after reset.
   logic last_grant;

   always_comb begin
      grant0 = elig0 & (~elig1 | last_grant);
      grant1 = elig1 & (~elig0 | ~last_grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (grant0) begin
         last_grant <= 1'b0;
      end else if (grant1) begin
         last_grant <= 1'b1;
      end
   end
`else
   // Fixed priority: port 0 always wins; no grant history is needed.
   always_comb begin
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
   end
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Operand steering: port 0 drives the ALU unless port 1 holds the grant.
   // When nobody is granted the ALU output is simply not captured.
   always_comb begin
      if (grant1) begin
         alu_a    = req1_a;
         alu_b    = req1_b;
         alu_oper = req1_oper;
         alu_sign = req1_sign;
      end else begin
         alu_a    = req0_a;
         alu_b    = req0_b;
         alu_oper = req0_oper;
         alu_sign = req0_sign;
      end
   end

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .oper   (alu_oper),
      .sign   (alu_sign),
      .result (alu_y)
   );

   // ---- stage p0 -> p1: capture the granted result per port ----
   // A new acceptance wins over a drain, so back-to-back operations keep
   // valid high. A drain alone only drops valid; the data stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0_p1    <= 1'b0;
         result0_p1 <= '0;
      end else if (grant0) begin
         vld0_p1    <= 1'b1;
         result0_p1 <= alu_y;
      end else if (rsp0_ready) begin
         vld0_p1    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_p1    <= 1'b0;
         result1_p1 <= '0;
      end else if (grant1) begin
         vld1_p1    <= 1'b1;
         result1_p1 <= alu_y;
      end else if (rsp1_ready) begin
         vld1_p1    <= 1'b0;
      end
   end

   assign rsp0_valid  = vld0_p1;
   assign rsp0_result = result0_p1;
   assign rsp1_valid  = vld1_p1;
   assign rsp1_result = result1_p1;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Scoreboard bench for alu_arbiter. The driver issues one cycle of stimulus at
// a time, predicts the grant from a queue-based model of each port's result
// slot, and pushes the expected ALU result for every accepted operation. The
// monitor independently compares the presented responses against the queue
// heads and retires them when the consumer is ready.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDU = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SUBU = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SL   = 4'd9;
   localparam logic [3:0] OP_SR   = 4'd10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_oper = '0, req1_oper = '0;
   logic        req0_sign = 1'b0, req1_sign = 1'b0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_result, rsp1_result;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_oper   (req0_oper),
      .req0_sign   (req0_sign),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_oper   (req1_oper),
      .req1_sign   (req1_sign),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result)
   );

   int          tests = 0;
   int          fails = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic        last = 1'b1;   // model of the last granted port
   logic        g0, g1;        // readies observed in the latest cycle

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU written from the operation definitions.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic s);
      logic [4:0]  n;
      logic [31:0] r;
      n = a[4:0];
      r = '0;
      case (op)
         OP_ADD, OP_ADDU: r = a + b;
         OP_SUB, OP_SUBU: r = a - b;
         OP_AND:          r = a & b;
         OP_OR:           r = a | b;
         OP_XOR:          r = a ^ b;
         OP_NOR:          r = ~(a | b);
         OP_SLT: begin
            // differing sign bits: the negative one is smaller
            if (s && (a[31] != b[31])) r = {31'b0, a[31]};
            else                       r = {31'b0, (a < b)};
         end
         OP_SL:           r = b << n;
         OP_SR: begin
            r = b >> n;
            if (s && b[31]) r = r | ~(32'hFFFF_FFFF >> n);
         end
         default:         r = '0;
      endcase
      return r;
   endfunction

   // Monitor: each result slot is modelled as a queue holding at most one entry.
   always @(negedge clk) begin
      #1;
      if (q0.size() > 0) begin
         check("rsp0_valid held", 32'(rsp0_valid), 32'd1);
         check("rsp0_result", rsp0_result, q0[0]);
         if (rsp0_ready) void'(q0.pop_front());
      end else begin
         check("rsp0_valid empty", 32'(rsp0_valid), 32'd0);
      end
      if (q1.size() > 0) begin
         check("rsp1_valid held", 32'(rsp1_valid), 32'd1);
         check("rsp1_result", rsp1_result, q1[0]);
         if (rsp1_ready) void'(q1.pop_front());
      end else begin
         check("rsp1_valid empty", 32'(rsp1_valid), 32'd0);
      end
   end

   // One cycle of stimulus; releases reset if it was held.
   task automatic cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] o0, input logic s0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic [3:0] o1, input logic s1,
                        input logic rr0, input logic rr1);
      logic e0, e1;
      int   gp;
      @(negedge clk);
      rst_n      = 1'b1;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_oper = o0; req0_sign = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_oper = o1; req1_sign = s1;
      rsp0_ready = rr0;
      rsp1_ready = rr1;
      #2;
      // after the monitor's pop, an empty queue means the slot can take data
      e0 = v0 && (q0.size() == 0);
      e1 = v1 && (q1.size() == 0);
      gp = -1;
      if (e0 && e1) begin
`ifdef ALU_ARB_RR_EN
         gp = last ? 0 : 1;
`else
         gp = 0;
`endif
      end else if (e0) begin
         gp = 0;
      end else if (e1) begin
         gp = 1;
      end
      check("req0_ready", 32'(req0_ready), 32'(gp == 0));
      check("req1_ready", 32'(req1_ready), 32'(gp == 1));
      g0 = req0_ready;
      g1 = req1_ready;
      if (gp == 0) begin
         q0.push_back(model(a0, b0, o0, s0));
         last = 1'b0;
      end else if (gp == 1) begin
         q1.push_back(model(a1, b1, o1, s1));
         last = 1'b1;
      end
   endtask

   // Assert reset for one full cycle with both requesters asking.
   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      q0.delete();
      q1.delete();
      last = 1'b1;
      #3;
      check("reset req0_ready", 32'(req0_ready), 32'd0);
      check("reset req1_ready", 32'(req1_ready), 32'd0);
      check("reset rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("reset rsp1_valid", 32'(rsp1_valid), 32'd0);
      check("reset rsp0_result", rsp0_result, 32'd0);
      check("reset rsp1_result", rsp1_result, 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] seq;
      logic [3:0] seq_exp;

      do_reset();

      // single ADD 5 + 7 on port 0, held with consumer not ready
      cycle(1, 5, 7, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  0, 0);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  0, 0);
      check("add rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("add 5+7", rsp0_result, 32'd12);

      // backpressure: slot 0 full and not draining, port 1 gets served
      cycle(1, 10, 3, OP_SUB, 0,  1, 2, 9, OP_ADD, 0,  0, 1);
      check("bp req0 blocked", 32'(g0), 32'd0);
      check("bp req1 served", 32'(g1), 32'd1);
      cycle(1, 10, 3, OP_SUB, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      check("bp drain+accept", 32'(g0), 32'd1);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  0, 1);
      check("sub 10-3", rsp0_result, 32'd7);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);

      // signed/unsigned compare and arithmetic shift
      cycle(1, 32'hFFFF_FFFF, 1, OP_SLT, 1,  0, 0, 0, OP_ADD, 0,  1, 1);
      cycle(1, 32'hFFFF_FFFF, 1, OP_SLT, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      check("slt signed", rsp0_result, 32'd1);
      cycle(1, 4, 32'h8000_0000, OP_SR, 1,  0, 0, 0, OP_ADD, 0,  1, 1);
      check("slt unsigned", rsp0_result, 32'd0);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      check("sra", rsp0_result, 32'hF800_0000);

      // undefined opcode yields zero
      cycle(1, 32'h1234, 32'h5678, 4'd15, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      check("undefined op", rsp0_result, 32'd0);

      // mid-operation reset with an undelivered result on port 1
      cycle(0, 0, 0, OP_ADD, 0,  1, 3, 4, OP_ADD, 0,  0, 0);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  0, 0);
      check("pre-reset rsp1_valid", 32'(rsp1_valid), 32'd1);
      do_reset();

      // conflict for four cycles with consumers always ready
      for (int i = 0; i < 4; i++) begin
         cycle(1, i, 1, OP_ADD, 0,  1, i, 2, OP_ADD, 0,  1, 1);
         seq[i] = g1;
      end
`ifdef ALU_ARB_RR_EN
      seq_exp = 4'b1010;
`else
      seq_exp = 4'b0000;
`endif
      check("conflict grant sequence", 32'(seq), 32'(seq_exp));

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         cycle($urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      end

      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);
      cycle(0, 0, 0, OP_ADD, 0,  0, 0, 0, OP_ADD, 0,  1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
